// File: rtl/dcache_victim_buffer_if.sv
// Bus bundle for the DCache write-back victim buffer: DCache eviction/refill side
// and AXI interface write/read side. "slave" is the buffer, "master" its environment.
interface dcache_victim_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              in_wr_req;
    logic [ADDR_W-1:0] in_wr_addr;
    logic [LINE_W-1:0] in_wr_data;
    logic              in_wr_rdy;
    logic              up_rd_req;
    logic [ADDR_W-1:0] up_rd_addr;
    logic              up_rd_rdy;
    logic              up_ret_valid;
    logic [LINE_W-1:0] up_ret_data;
    logic              dn_wr_req;
    logic [ADDR_W-1:0] dn_wr_addr;
    logic [LINE_W-1:0] dn_wr_data;
    logic              dn_wr_rdy;
    logic              dn_rd_req;
    logic [ADDR_W-1:0] dn_rd_addr;
    logic              dn_rd_rdy;
    logic              dn_ret_valid;
    logic [LINE_W-1:0] dn_ret_data;
    logic              vb_empty;

    modport slave (
        input  in_wr_req, in_wr_addr, in_wr_data, up_rd_req, up_rd_addr,
               dn_wr_rdy, dn_rd_rdy, dn_ret_valid, dn_ret_data,
        output in_wr_rdy, up_rd_rdy, up_ret_valid, up_ret_data,
               dn_wr_req, dn_wr_addr, dn_wr_data, dn_rd_req, dn_rd_addr, vb_empty
    );

    modport master (
        output in_wr_req, in_wr_addr, in_wr_data, up_rd_req, up_rd_addr,
               dn_wr_rdy, dn_rd_rdy, dn_ret_valid, dn_ret_data,
        input  in_wr_rdy, up_rd_rdy, up_ret_valid, up_ret_data,
               dn_wr_req, dn_wr_addr, dn_wr_data, dn_rd_req, dn_rd_addr, vb_empty
    );
endinterface

// File: rtl/dcache_victim_buffer.sv
// In-order write-back victim FIFO with refill pass-through and RAW hazard handling.
// Define VBUF_FWD_EN to forward hazarding refills from the buffer instead of stalling.
module dcache_victim_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic                  clk,
    input  logic                  resetn,
    dcache_victim_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        RD_IDLE       = 3'd0,
        RD_CHECK      = 3'd1,
`ifdef VBUF_FWD_EN
        RD_FWD        = 3'd2,
`endif
        RD_WAIT_DRAIN = 3'd3,
        RD_REQ        = 3'd4,
        RD_WAIT       = 3'd5
    } rd_state_e;

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [LINE_W-1:0] mem_data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    rd_state_e         rd_state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              up_rd_rdy_q;
    logic              up_ret_valid_q;
    logic [LINE_W-1:0] up_ret_data_q;
    logic              dn_rd_req_q;

    logic              in_wr_rdy_s, dn_wr_req_s, push_s, pop_s;
    logic              hit_s, match_s;
    logic [PTR_W-1:0]  entry_s;
`ifdef VBUF_FWD_EN
    logic [LINE_W-1:0] fwd_data_s;
`endif

    // A full buffer refuses the push even when the head is popped that cycle.
    assign in_wr_rdy_s = (count_q < CNT_W'(DEPTH));
    assign dn_wr_req_s = (count_q != {CNT_W{1'b0}});
    assign push_s      = bus.in_wr_req && in_wr_rdy_s;
    assign pop_s       = dn_wr_req_s && bus.dn_wr_rdy;

    assign bus.in_wr_rdy    = in_wr_rdy_s;
    assign bus.dn_wr_req    = dn_wr_req_s;
    assign bus.dn_wr_addr   = mem_addr_q[rd_ptr_q];
    assign bus.dn_wr_data   = mem_data_q[rd_ptr_q];
    assign bus.vb_empty     = ~dn_wr_req_s;
    assign bus.up_rd_rdy    = up_rd_rdy_q;
    assign bus.up_ret_valid = up_ret_valid_q;
    assign bus.up_ret_data  = up_ret_data_q;
    assign bus.dn_rd_req    = dn_rd_req_q;
    assign bus.dn_rd_addr   = rd_addr_q;

    // Occupancy and per-entry valid next state.
    always_comb begin
        count_d = count_q;
        valid_d = valid_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        valid_d[rd_ptr_q] = valid_q[rd_ptr_q] & ~pop_s;
        valid_d[wr_ptr_q] = valid_d[wr_ptr_q] | push_s;
    end

    // Line-address hazard scan, oldest to youngest so the last match is the youngest.
    always_comb begin
        hit_s   = 1'b0;
        match_s = 1'b0;
        entry_s = {PTR_W{1'b0}};
`ifdef VBUF_FWD_EN
        fwd_data_s = {LINE_W{1'b0}};
`endif
        for (int i = 0; i < DEPTH; i++) begin
            entry_s = rd_ptr_q + PTR_W'(i);
            match_s = valid_q[entry_s] &&
                      (mem_addr_q[entry_s][ADDR_W-1:4] == rd_addr_q[ADDR_W-1:4]);
            hit_s   = hit_s | match_s;
`ifdef VBUF_FWD_EN
            fwd_data_s = match_s ? mem_data_q[entry_s] : fwd_data_s;
`endif
        end
    end

    // Victim FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            valid_q  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= {ADDR_W{1'b0}};
                mem_data_q[i] <= {LINE_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_addr_q[wr_ptr_q] <= bus.in_wr_addr;
                mem_data_q[wr_ptr_q] <= bus.in_wr_data;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Refill FSM: one outstanding refill, hazard check against queued victims.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state_q     <= RD_IDLE;
            rd_addr_q      <= {ADDR_W{1'b0}};
            up_rd_rdy_q    <= 1'b1;
            up_ret_valid_q <= 1'b0;
            up_ret_data_q  <= {LINE_W{1'b0}};
            dn_rd_req_q    <= 1'b0;
        end else begin
            up_ret_valid_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    if (bus.up_rd_req) begin
                        rd_addr_q   <= bus.up_rd_addr;
                        up_rd_rdy_q <= 1'b0;
                        rd_state_q  <= RD_CHECK;
                    end
                end
                RD_CHECK: begin
                    if (hit_s) begin
`ifdef VBUF_FWD_EN
                        up_ret_valid_q <= 1'b1;
                        up_ret_data_q  <= fwd_data_s;
                        rd_state_q     <= RD_FWD;
`else
                        rd_state_q     <= RD_WAIT_DRAIN;
`endif
                    end else begin
                        dn_rd_req_q <= 1'b1;
                        rd_state_q  <= RD_REQ;
                    end
                end
`ifdef VBUF_FWD_EN
                RD_FWD: begin
                    up_rd_rdy_q <= 1'b1;
                    rd_state_q  <= RD_IDLE;
                end
`endif
                RD_WAIT_DRAIN: begin
                    if (!hit_s) begin
                        dn_rd_req_q <= 1'b1;
                        rd_state_q  <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bus.dn_rd_rdy) begin
                        dn_rd_req_q <= 1'b0;
                        rd_state_q  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.dn_ret_valid) begin
                        up_ret_valid_q <= 1'b1;
                        up_ret_data_q  <= bus.dn_ret_data;
                        up_rd_rdy_q    <= 1'b1;
                        rd_state_q     <= RD_IDLE;
                    end
                end
                default: begin
                    dn_rd_req_q <= 1'b0;
                    up_rd_rdy_q <= 1'b1;
                    rd_state_q  <= RD_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Scoreboard bench for dcache_victim_buffer; expectations follow VBUF_FWD_EN.
module tb_dcache_victim_buffer;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_item_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dcache_victim_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();
    dcache_victim_buffer #(.DEPTH(4), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    wr_item_t     wr_exp_q [$];
    logic [127:0] rd_exp_q [$];
    logic [127:0] mem_model [logic [27:0]];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc, ret_cyc, rd_req_cyc, dnret_cyc, last_pop_cyc;
    bit rd_req_seen;
    logic [31:0] rd_req_addr;

    task automatic check_value(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] s);
        return {s, s + 32'd1, ~s, s ^ 32'h5A5A_5A5A};
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        if (mem_model.exists(a[31:4])) return mem_model[a[31:4]];
        else return {a[31:4], 4'h0, ~a, a ^ 32'hA5A5_A5A5, 32'h600D_F00D};
    endfunction

    always @(posedge clk) cyc++;

    // Output monitor: write-port scoreboard, refill-return scoreboard, timing marks.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.dn_wr_req && bus.dn_wr_rdy) begin
                mem_model[bus.dn_wr_addr[31:4]] = bus.dn_wr_data;
                last_pop_cyc = cyc;
                check_value("dn_wr_expected", 128'(wr_exp_q.size() != 0), 128'd1);
                if (wr_exp_q.size() != 0) begin
                    wr_item_t it;
                    it = wr_exp_q.pop_front();
                    check_value("dn_wr_addr", 128'(bus.dn_wr_addr), 128'(it.addr));
                    check_value("dn_wr_data", bus.dn_wr_data, it.data);
                end
            end
            if (bus.up_ret_valid) begin
                ret_cyc = cyc;
                check_value("up_ret_expected", 128'(rd_exp_q.size() != 0), 128'd1);
                if (rd_exp_q.size() != 0) check_value("up_ret_data", bus.up_ret_data, rd_exp_q.pop_front());
            end
            if (bus.dn_rd_req && !rd_req_seen) begin
                rd_req_seen = 1'b1;
                rd_req_cyc  = cyc;
                rd_req_addr = bus.dn_rd_addr;
            end
            if (bus.dn_ret_valid) dnret_cyc = cyc;
        end
    end

    // AXI read responder: data one cycle after the accepted read.
    initial begin
        bit hs;
        logic [127:0] line;
        bus.dn_ret_valid = 1'b0;
        bus.dn_ret_data  = '0;
        forever begin
            @(negedge clk);
            hs   = resetn && bus.dn_rd_req && bus.dn_rd_rdy;
            line = mem_line(bus.dn_rd_addr);
            @(posedge clk);
            #1;
            bus.dn_ret_valid = hs;
            bus.dn_ret_data  = hs ? line : 128'd0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [31:0] a, input logic [127:0] d);
        wr_item_t it;
        int n = 0;
        while (!bus.in_wr_rdy && n < 50) begin tick(); n++; end
        check_value("push_rdy", 128'(bus.in_wr_rdy), 128'd1);
        it.addr = a;
        it.data = d;
        wr_exp_q.push_back(it);
        bus.in_wr_req  = 1'b1;
        bus.in_wr_addr = a;
        bus.in_wr_data = d;
        tick();
        bus.in_wr_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.dn_wr_rdy = 1'b1;
        while (!bus.vb_empty && n < 50) begin tick(); n++; end
        bus.dn_wr_rdy = 1'b0;
        check_value("drain_empty", 128'(bus.vb_empty), 128'd1);
        check_value("drain_sb", 128'(wr_exp_q.size()), 128'd0);
    endtask

    task automatic refill_start(input logic [31:0] a, input logic [127:0] exp);
        int n = 0;
        while (!bus.up_rd_rdy && n < 50) begin tick(); n++; end
        check_value("refill_rdy", 128'(bus.up_rd_rdy), 128'd1);
        rd_req_seen = 1'b0;
        rd_exp_q.push_back(exp);
        bus.up_rd_req  = 1'b1;
        bus.up_rd_addr = a;
        acc_cyc = cyc;
        tick();
        bus.up_rd_req = 1'b0;
    endtask

    task automatic refill_wait();
        int n = 0;
        while (rd_exp_q.size() != 0 && n < 100) begin tick(); n++; end
        check_value("refill_done", 128'(rd_exp_q.size()), 128'd0);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.in_wr_req  = 1'b0;
        bus.in_wr_addr = '0;
        bus.in_wr_data = '0;
        bus.up_rd_req  = 1'b0;
        bus.up_rd_addr = '0;
        bus.dn_wr_rdy  = 1'b0;
        bus.dn_rd_rdy  = 1'b1;
        repeat (3) tick();
        check_value("rst_in_wr_rdy", 128'(bus.in_wr_rdy), 128'd1);
        check_value("rst_up_rd_rdy", 128'(bus.up_rd_rdy), 128'd1);
        check_value("rst_up_ret_valid", 128'(bus.up_ret_valid), 128'd0);
        check_value("rst_dn_wr_req", 128'(bus.dn_wr_req), 128'd0);
        check_value("rst_dn_rd_req", 128'(bus.dn_rd_req), 128'd0);
        check_value("rst_vb_empty", 128'(bus.vb_empty), 128'd1);
        check_value("rst_up_ret_data", bus.up_ret_data, 128'd0);
        check_value("rst_dn_wr_data", bus.dn_wr_data, 128'd0);
        check_value("rst_dn_rd_addr", 128'(bus.dn_rd_addr), 128'd0);
        resetn = 1'b1;
        tick();

        // Fill to capacity, refused fifth push, in-order drain.
        for (int i = 0; i < 4; i++) push_line(32'h0000_4000 + 32'(i * 16), mk_line(32'h1000 + 32'(i)));
        check_value("t1_full_rdy", 128'(bus.in_wr_rdy), 128'd0);
        check_value("t1_not_empty", 128'(bus.vb_empty), 128'd0);
        bus.in_wr_req  = 1'b1;
        bus.in_wr_addr = 32'h0000_4040;
        bus.in_wr_data = mk_line(32'hDEAD);
        repeat (2) tick();
        check_value("t1_refused_rdy", 128'(bus.in_wr_rdy), 128'd0);
        bus.in_wr_req = 1'b0;
        check_value("t1_head_addr", 128'(bus.dn_wr_addr), 128'h4000);
        drain();

        // Full buffer, push and pop in the same cycle.
        for (int i = 0; i < 4; i++) push_line(32'h0000_5000 + 32'(i * 16), mk_line(32'h2000 + 32'(i)));
        bus.in_wr_req  = 1'b1;
        bus.in_wr_addr = 32'h0000_5040;
        bus.in_wr_data = mk_line(32'hBEEF);
        bus.dn_wr_rdy  = 1'b1;
        tick();
        bus.in_wr_req = 1'b0;
        bus.dn_wr_rdy = 1'b0;
        check_value("t2_count3_rdy", 128'(bus.in_wr_rdy), 128'd1);
        check_value("t2_head_addr", 128'(bus.dn_wr_addr), 128'h5010);
        drain();

        // Refill with an empty buffer.
        refill_start(32'h0000_1000, mem_line(32'h0000_1000));
        refill_wait();
        check_value("t3_rd_req_seen", 128'(rd_req_seen), 128'd1);
        check_value("t3_rd_req_lat", 128'(rd_req_cyc - acc_cyc), 128'd2);
        check_value("t3_rd_addr", 128'(rd_req_addr), 128'h1000);
        check_value("t3_ret_after_dn", 128'(ret_cyc - dnret_cyc), 128'd1);
        check_value("t3_ret_lat", 128'(ret_cyc - acc_cyc), 128'd4);

        // Refill hitting a queued line.
        push_line(32'h0000_2000, mk_line(32'hAAAA));
        refill_start(32'h0000_2004, mk_line(32'hAAAA));
`ifdef VBUF_FWD_EN
        refill_wait();
        check_value("t4_no_axi", 128'(rd_req_seen), 128'd0);
        check_value("t4_fwd_lat", 128'(ret_cyc - acc_cyc), 128'd2);
`else
        repeat (6) tick();
        check_value("t4_stall", 128'(rd_req_seen), 128'd0);
        check_value("t4_still_queued", 128'(bus.vb_empty), 128'd0);
        bus.dn_wr_rdy = 1'b1;
        refill_wait();
        bus.dn_wr_rdy = 1'b0;
        check_value("t4_rd_req_seen", 128'(rd_req_seen), 128'd1);
        check_value("t4_after_pop", 128'(rd_req_cyc > last_pop_cyc), 128'd1);
`endif
        drain();

        // Same line evicted twice: the younger copy wins.
        push_line(32'h0000_3000, mk_line(32'hBBBB));
        push_line(32'h0000_3000, mk_line(32'hCCCC));
        refill_start(32'h0000_3000, mk_line(32'hCCCC));
`ifdef VBUF_FWD_EN
        refill_wait();
        check_value("t5_no_axi", 128'(rd_req_seen), 128'd0);
`else
        repeat (4) tick();
        check_value("t5_stall", 128'(rd_req_seen), 128'd0);
        bus.dn_wr_rdy = 1'b1;
        refill_wait();
        bus.dn_wr_rdy = 1'b0;
`endif
        drain();

        // Reset mid-operation with queued entries and an in-flight refill.
        bus.dn_rd_rdy = 1'b0;
        for (int i = 0; i < 3; i++) push_line(32'h0000_6000 + 32'(i * 16), mk_line(32'h3000 + 32'(i)));
        bus.up_rd_req  = 1'b1;
        bus.up_rd_addr = 32'h0000_7000;
        tick();
        bus.up_rd_req = 1'b0;
        repeat (3) tick();
        check_value("t6_pre_wr_req", 128'(bus.dn_wr_req), 128'd1);
        check_value("t6_pre_rd_req", 128'(bus.dn_rd_req), 128'd1);
        resetn = 1'b0;
        tick();
        check_value("t6_dn_wr_req", 128'(bus.dn_wr_req), 128'd0);
        check_value("t6_vb_empty", 128'(bus.vb_empty), 128'd1);
        check_value("t6_up_rd_rdy", 128'(bus.up_rd_rdy), 128'd1);
        check_value("t6_dn_rd_req", 128'(bus.dn_rd_req), 128'd0);
        check_value("t6_in_wr_rdy", 128'(bus.in_wr_rdy), 128'd1);
        wr_exp_q.delete();
        resetn        = 1'b1;
        bus.dn_rd_rdy = 1'b1;
        tick();

        refill_start(32'h0000_1000, mem_line(32'h0000_1000));
        refill_wait();
        check_value("t7_rd_req_seen", 128'(rd_req_seen), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
